// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite definitions: controller state encoding, response codes
// and default bus widths. Used by the master controller, the slave and the bench.
package axilite_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_RESP_W = 2;
  localparam int unsigned CTRL_LAT_W = 16;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_AW = 3'd1,
    WR_B  = 3'd2,
    RD_A  = 3'd3,
    RD_R  = 3'd4,
    RSP   = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/axilite_m_ctrl.sv
// Single-outstanding AXI4-Lite master controller.
// Turns a cmd/rsp request interface into one AXI-Lite write (AW+W -> B) or
// read (AR -> R) at a time, and reports a saturating per-transaction latency.
// Ports:
//   s_axi_aclk / s_axi_aresetn        clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata  command request (accepted on valid&&ready)
//   rsp_valid/ready/rdata/resp/lat    response, held until rsp_ready
//   m_axi_aw*/w*/b*                   AXI-Lite write channels
//   m_axi_ar*/r*                      AXI-Lite read channels
// All outputs come straight from registers.
module axilite_m_ctrl
  import axilite_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W,
  parameter int unsigned LAT_W  = CTRL_LAT_W
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [AXI_RESP_W-1:0] rsp_resp,
  output logic [LAT_W-1:0]      rsp_lat,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [AXI_RESP_W-1:0] m_axi_bresp,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [AXI_RESP_W-1:0] m_axi_rresp
);

  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  ctrl_state_e           state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [AXI_RESP_W-1:0] rsp_resp_q, rsp_resp_d;
  logic [LAT_W-1:0]      rsp_lat_q, rsp_lat_d;
  logic [LAT_W-1:0]      lat_q, lat_d;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_lat_d   = rsp_lat_q;
    // Free-running saturating counter; restarted at 1 for the first valid cycle
    lat_d       = (lat_q == LAT_MAX) ? lat_q : lat_q + LAT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          lat_d   = LAT_W'(1);
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_A;
          end
        end
      end
      WR_AW: begin
        // AW and W complete independently, in either order
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (m_axi_bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
          rsp_lat_d   = lat_q;
          state_d     = RSP;
        end
      end
      RD_A: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (m_axi_rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          rsp_lat_d   = lat_q;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered copy of (state == IDLE); stays low while in reset
    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      rsp_lat_q   <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_lat_q   <= rsp_lat_d;
      lat_q       <= lat_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_lat       = rsp_lat_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axilite_m_ctrl.sv
// Bench for axilite_m_ctrl: two instances (LAT_W=16 and LAT_W=4) in lockstep
// behind one delay-programmable AXI-Lite memory slave. Expected responses come
// from an address-keyed memory model; expected latency from the programmed
// slave delays.
module tb_axilite_m_ctrl;
  import axilite_pkg::*;

  typedef logic [127:0] cv_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Command side (driven by the main sequence)
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr  = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_ready = 1'b0;

  // Slave side (driven by the slave process)
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic        arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  // DUT outputs, 16-bit latency instance
  logic        cmd_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_lat;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;

  // DUT outputs, 4-bit latency instance
  logic        cmd_ready4, rsp_valid4;
  logic [31:0] rsp_rdata4;
  logic [1:0]  rsp_resp4;
  logic [3:0]  rsp_lat4;
  logic        awvalid4, wvalid4, bready4, arvalid4, rready4;
  logic [31:0] awaddr4, wdata4, araddr4;

  logic axi_busy;
  assign axi_busy = awvalid | wvalid | arvalid | bready | rready;

  axilite_m_ctrl #(.ADDR_W(32), .DATA_W(32), .LAT_W(16)) u_dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_lat(rsp_lat),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp)
  );

  axilite_m_ctrl #(.ADDR_W(32), .DATA_W(32), .LAT_W(4)) u_dut4 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata4),
    .rsp_resp(rsp_resp4), .rsp_lat(rsp_lat4),
    .m_axi_awvalid(awvalid4), .m_axi_awready(awready), .m_axi_awaddr(awaddr4),
    .m_axi_wvalid(wvalid4), .m_axi_wready(wready), .m_axi_wdata(wdata4),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready4), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid4), .m_axi_arready(arready), .m_axi_araddr(araddr4),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready4), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input cv_t got, input cv_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Address map of the bench slave: RAM below 0x100, SLVERR window, DECERR above
  function automatic logic [1:0] region_resp(input logic [31:0] a);
    if (a < 32'h100) return RESP_OKAY;
    if (a < 32'h200) return RESP_SLVERR;
    return RESP_DECERR;
  endfunction

  // ---------------- Slave: ready/valid delays programmed per transaction ----
  int da = 0, dw = 0, db = 0;        // written by main sequence before a command
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  bit aw_done = 0, w_done = 0, ar_done = 0, b_hs = 0, r_hs = 0;
  int aw_tot = 0, w_tot = 0, b_tot = 0, ar_tot = 0, r_tot = 0, v4_bad = 0;
  logic [31:0] cap_aw = '0, cap_aw4 = '0, cap_w = '0, cap_w4 = '0;
  logic [31:0] cap_ar = '0, cap_ar4 = '0;
  logic [31:0] slv_mem [64] = '{default: '0};

  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = '0; rresp = '0; rdata = '0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_done = 0; w_done = 0; ar_done = 0; b_hs = 0; r_hs = 0;
    end else begin
      // B: starts db cycles after both AW and W were accepted
      if (b_hs) begin
        if (region_resp(cap_aw) == RESP_OKAY) slv_mem[cap_aw[7:2]] = cap_w;
        bvalid = 0; b_hs = 0; b_tot++;
        aw_done = 0; w_done = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else if (aw_done && w_done) begin
        if (b_cnt >= db) begin
          bvalid = 1; bresp = region_resp(cap_aw); b_hs = bready;
          if (bready && !bready4) v4_bad++;
        end else b_cnt++;
      end
      // R: starts db cycles after AR was accepted
      if (r_hs) begin
        rvalid = 0; r_hs = 0; r_tot++;
        ar_done = 0; ar_cnt = 0; r_cnt = 0;
      end else if (ar_done) begin
        if (r_cnt >= db) begin
          rvalid = 1; rresp = region_resp(cap_ar);
          rdata = (rresp == RESP_OKAY) ? slv_mem[cap_ar[7:2]] : '0;
          r_hs = rready;
          if (rready && !rready4) v4_bad++;
        end else r_cnt++;
      end
      // AW / W / AR: ready after the valid has been seen for da (dw) cycles
      awready = 0;
      if (awvalid && !aw_done) begin
        if (aw_cnt >= da) begin
          awready = 1; aw_done = 1; aw_tot++; cap_aw = awaddr; cap_aw4 = awaddr4;
          if (!awvalid4) v4_bad++;
        end else aw_cnt++;
      end
      wready = 0;
      if (wvalid && !w_done) begin
        if (w_cnt >= dw) begin
          wready = 1; w_done = 1; w_tot++; cap_w = wdata; cap_w4 = wdata4;
          if (!wvalid4) v4_bad++;
        end else w_cnt++;
      end
      arready = 0;
      if (arvalid && !ar_done) begin
        if (ar_cnt >= da) begin
          arready = 1; ar_done = 1; ar_tot++; cap_ar = araddr; cap_ar4 = araddr4;
          if (!arvalid4) v4_bad++;
        end else ar_cnt++;
      end
    end
  end

  // ---------------- Reference model ----------------------------------------
  logic [31:0] ref_mem [logic [31:0]];

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input int t_da, input int t_dw, input int t_db, input int hold);
    int n, lat, lat16, lat4;
    int aw0, w0, b0, ar0, r0, v0;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    logic [39:0] e_hs, g_hs;
    aw0 = aw_tot; w0 = w_tot; b0 = b_tot; ar0 = ar_tot; r0 = r_tot; v0 = v4_bad;
    e_resp  = region_resp(addr);
    e_rdata = '0;
    if (!wr && e_resp == RESP_OKAY && ref_mem.exists(addr)) e_rdata = ref_mem[addr];
    if (wr && e_resp == RESP_OKAY) ref_mem[addr] = wd;
    // Latency: first valid cycle is 1; response channel opens one cycle after
    // the address phase(s) and the slave adds t_db more cycles
    lat   = wr ? ((t_da > t_dw ? t_da : t_dw) + 2 + t_db) : (t_da + 2 + t_db);
    lat16 = (lat > 65535) ? 65535 : lat;
    lat4  = (lat > 15) ? 15 : lat;
    e_hs  = wr ? {8'd1, 8'd1, 8'd1, 8'd0, 8'd0} : {8'd0, 8'd0, 8'd0, 8'd1, 8'd1};

    @(negedge clk);
    da = t_da; dw = t_dw; db = t_db;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_accept", cv_t'(cmd_ready), cv_t'(1'b1));
    @(negedge clk);
    cmd_valid = 0;
    if (n >= 50) return;

    n = 0;
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    chk("rsp_arrive", cv_t'(rsp_valid), cv_t'(1'b1));
    if (!rsp_valid) return;

    for (int i = 0; i < hold; i++) begin
      chk("rsp_hold", cv_t'({rsp_valid, rsp_rdata, rsp_resp, cmd_ready, axi_busy}),
          cv_t'({1'b1, e_rdata, e_resp, 1'b0, 1'b0}));
      @(negedge clk);
    end

    chk("rsp_resp",  cv_t'(rsp_resp),  cv_t'(e_resp));
    chk("rsp_rdata", cv_t'(rsp_rdata), cv_t'(e_rdata));
    chk("rsp_lat16", cv_t'(rsp_lat),   cv_t'(lat16));
    chk("rsp_lat4",  cv_t'(rsp_lat4),  cv_t'(lat4));
    chk("rsp_dut4",  cv_t'({rsp_valid4, rsp_resp4, rsp_rdata4}),
        cv_t'({1'b1, e_resp, e_rdata}));

    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    #1;
    chk("rsp_release", cv_t'({rsp_valid, cmd_ready, cmd_ready4, axi_busy}),
        cv_t'(4'b0110));
    g_hs = {8'(aw_tot - aw0), 8'(w_tot - w0), 8'(b_tot - b0), 8'(ar_tot - ar0), 8'(r_tot - r0)};
    chk("handshakes", cv_t'(g_hs), cv_t'(e_hs));
    chk("dut4_lockstep", cv_t'(v4_bad - v0), cv_t'(0));
    if (wr) begin
      chk("aw_addr", cv_t'({cap_aw, cap_aw4}), cv_t'({addr, addr}));
      chk("w_data",  cv_t'({cap_w, cap_w4}),   cv_t'({wd, wd}));
    end else begin
      chk("ar_addr", cv_t'({cap_ar, cap_ar4}), cv_t'({addr, addr}));
    end
  endtask

  // ---------------- Main sequence ------------------------------------------
  initial begin
    int n;
    logic [31:0] a;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", cv_t'({cmd_ready, rsp_valid, axi_busy, rsp_resp, cmd_ready4, rsp_valid4}),
        cv_t'(0));
    chk("rst_data", cv_t'({rsp_rdata, rsp_lat, rsp_lat4}), cv_t'(0));
    #2 rst_n = 1;
    #1 chk("rel_cmd_ready0", cv_t'({cmd_ready, cmd_ready4}), cv_t'(2'b00));
    @(negedge clk);
    chk("rel_cmd_ready1", cv_t'({cmd_ready, cmd_ready4}), cv_t'(2'b11));

    // Basic write/read, out-of-range, SLVERR passthrough
    run_cmd(1, 32'h10,  32'hDEADBEEF, 0, 0, 0, 0);
    run_cmd(0, 32'h10,  32'h0,        0, 0, 0, 0);
    run_cmd(1, 32'h200, 32'h12345678, 0, 0, 0, 0);
    run_cmd(0, 32'h200, 32'h0,        1, 0, 1, 0);
    run_cmd(1, 32'h104, 32'hCAFEF00D, 0, 1, 0, 0);
    // W before AW, AW stalled 5 cycles
    run_cmd(1, 32'h14,  32'hA5A5A5A5, 5, 0, 0, 0);
    // AW before W
    run_cmd(1, 32'h18,  32'h5A5A5A5A, 0, 4, 2, 1);
    // Response held off for 10 cycles
    run_cmd(0, 32'h10,  32'h0,        2, 0, 3, 10);
    // Slave stalls 20 cycles: 4-bit counter saturates
    run_cmd(0, 32'h14,  32'h0,        0, 0, 20, 0);
    run_cmd(1, 32'h1C,  32'h0BADC0DE, 3, 6, 20, 2);

    // Randomised traffic over a small address set so reads hit earlier writes
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       a = {24'h0, 2'b00, 4'($urandom_range(0, 15)), 2'b00};
      else if (sel == 8) a = 32'h100 + {24'h0, 4'($urandom_range(0, 15)), 4'h0};
      else               a = 32'h200 + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      run_cmd(bit'($urandom_range(0, 1)), a, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)));
    end

    // Reset while waiting for R data
    @(negedge clk);
    da = 0; dw = 0; db = 40;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!rready && n < 50) begin @(negedge clk); n++; end
    chk("rd_r_reached", cv_t'(rready), cv_t'(1'b1));
    #2 rst_n = 0;
    #1 chk("rst_abort", cv_t'({awvalid, wvalid, arvalid, bready, rready, cmd_ready, rsp_valid,
                               awvalid4, wvalid4, arvalid4, bready4, rready4, cmd_ready4, rsp_valid4}),
           cv_t'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    #1 chk("abort_rel0", cv_t'({cmd_ready, cmd_ready4}), cv_t'(2'b00));
    @(negedge clk);
    #1 chk("abort_rel1", cv_t'({cmd_ready, cmd_ready4, axi_busy}), cv_t'(3'b110));

    // Normal operation resumes after the abort
    run_cmd(1, 32'h20, 32'h600DF00D, 1, 2, 1, 0);
    run_cmd(0, 32'h20, 32'h0,        0, 0, 0, 1);
    run_cmd(0, 32'h10, 32'h0,        0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
